// File: rtl/seq_detector_param.sv
// Moore serial-pattern detector for an arbitrary LEN-bit PATTERN (MSB received first), with overlap mode,
// saturating match counter and synchronous clear. Define SEQ_DET_PROG_PATTERN_EN for a run-time loadable pattern.
module seq_detector_param #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1010,
  parameter int             CNT_W   = 8,
  parameter int             SW      = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             overlap_en,
  input  logic             clear,
`ifdef SEQ_DET_PROG_PATTERN_EN
  input  logic             pat_load,
  input  logic [LEN-1:0]   pat_in,
`endif
  output logic             detect,
  output logic [CNT_W-1:0] match_cnt,
  output logic [SW-1:0]    cs
);

  localparam logic [LEN-1:0] ONES = {LEN{1'b1}};

  // Bit 0 of the reversed pattern is the first bit on the wire, so a k-bit prefix is simply r & mask(k).
  function automatic int calc_next(input logic [LEN-1:0] p, input int st, input logic b);
    logic [LEN-1:0] r, s, m;
    int res;
    r   = {<<{p}};
    m   = ~(ONES << st);
    s   = (r & m) | (b ? ~m : '0);
    res = 0;
    for (int k = 1; k <= LEN; k++) begin
      if (k <= st + 1) begin
        m = ~(ONES << k);
        if (((s >> (st + 1 - k)) & m) == (r & m)) res = k;
      end
    end
    return res;
  endfunction

  function automatic int border(input logic [LEN-1:0] p);
    logic [LEN-1:0] r, m;
    int res;
    r   = {<<{p}};
    res = 0;
    for (int k = 1; k < LEN; k++) begin
      m = ~(ONES << k);
      if (((r >> (LEN - k)) & m) == (r & m)) res = k;
    end
    return res;
  endfunction

  logic [SW-1:0]    cs_q;
  logic             det_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SW-1:0]    nxt_len;
  logic [SW-1:0]    ovl_len;
  logic             hit;

`ifdef SEQ_DET_PROG_PATTERN_EN
  logic [LEN-1:0] pat_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    nxt_len = '0;
    ovl_len = SW'(border(pat_q));
    if (int'(cs_q) < LEN) nxt_len = SW'(calc_next(pat_q, int'(cs_q), in));
  end
`else
  function automatic logic [2*LEN*SW-1:0] build_tbl(input logic [LEN-1:0] p);
    logic [2*LEN*SW-1:0] t;
    t = '0;
    for (int st = 0; st < LEN; st++)
      for (int b = 0; b < 2; b++)
        t[(2*st + b)*SW +: SW] = SW'(calc_next(p, st, b[0]));
    return t;
  endfunction

  // Entry (state, bit) holds the new matched-prefix length; LEN means a full match.
  localparam logic [2*LEN*SW-1:0] NXT_TBL = build_tbl(PATTERN);
  localparam logic [SW-1:0]       OVL_ST  = SW'(border(PATTERN));

  int tbl_idx;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    nxt_len = '0;
    tbl_idx = (2 * int'(cs_q) + int'(in)) * SW;
    if (int'(cs_q) < LEN) nxt_len = NXT_TBL[tbl_idx +: SW];
  end

  assign ovl_len = OVL_ST;
`endif

  assign hit = (nxt_len == SW'(LEN));

  // NOTE: all state here is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q  <= '0;
      det_q <= 1'b0;
      cnt_q <= '0;
`ifdef SEQ_DET_PROG_PATTERN_EN
      pat_q <= PATTERN;
`endif
    end else begin
      det_q <= 1'b0;
`ifdef SEQ_DET_PROG_PATTERN_EN
      if (pat_load) pat_q <= pat_in;
`endif
      if (clear) begin
        cs_q  <= '0;
        cnt_q <= '0;
      end
`ifdef SEQ_DET_PROG_PATTERN_EN
      else if (pat_load) begin
        cs_q <= '0;
      end
`endif
      else if (int'(cs_q) >= LEN) begin
        cs_q <= '0;
      end else if (in_valid) begin
        if (hit) begin
          det_q <= 1'b1;
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          cs_q  <= overlap_en ? ovl_len : '0;
        end else begin
          cs_q <= nxt_len;
        end
      end
    end
  end

  assign detect    = det_q;
  assign match_cnt = cnt_q;
  assign cs        = cs_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default pattern 1010, a 1011 variant, and a 2-bit counter variant.
module tb_seq_detector_param;

  logic clk, rst, in_valid, din, overlap_en, clear;
`ifdef SEQ_DET_PROG_PATTERN_EN
  logic       pat_load;
  logic [3:0] pat_in;
`endif

  logic       a_det, b_det, c_det;
  logic [7:0] a_cnt, b_cnt;
  logic [1:0] c_cnt;
  logic [2:0] a_cs, b_cs, c_cs;

  int total = 0;
  int bad   = 0;

  seq_detector_param dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .overlap_en(overlap_en), .clear(clear),
`ifdef SEQ_DET_PROG_PATTERN_EN
    .pat_load(pat_load), .pat_in(pat_in),
`endif
    .detect(a_det), .match_cnt(a_cnt), .cs(a_cs)
  );

  seq_detector_param #(.LEN(4), .PATTERN(4'b1011)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .overlap_en(overlap_en), .clear(clear),
`ifdef SEQ_DET_PROG_PATTERN_EN
    .pat_load(pat_load), .pat_in(pat_in),
`endif
    .detect(b_det), .match_cnt(b_cnt), .cs(b_cs)
  );

  seq_detector_param #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .overlap_en(overlap_en), .clear(clear),
`ifdef SEQ_DET_PROG_PATTERN_EN
    .pat_load(pat_load), .pat_in(pat_in),
`endif
    .detect(c_det), .match_cnt(c_cnt), .cs(c_cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply one input cycle, then sample 1 ns after the edge.
  task automatic step(input logic v, input logic b);
    in_valid = v;
    din      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1'b1, 1'b0);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (a_cs !== 3'd0) begin bad++; $display("FAIL reset_cs got=%0d want=0", a_cs); end
    total++; if (a_det !== 1'b0) begin bad++; $display("FAIL reset_det got=%0d want=0", a_det); end
    total++; if (a_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", a_cnt); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_overlap();
    int bits [6]   = '{1, 0, 1, 0, 1, 0};
    int exp_cs [6] = '{1, 2, 3, 2, 3, 2};
    int exp_dt [6] = '{0, 0, 0, 1, 0, 1};
    overlap_en = 1'b1;
    do_clear();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, bits[i][0]);
      total++; if (a_det !== exp_dt[i][0]) begin bad++; $display("FAIL ovl_det[%0d] got=%0d want=%0d", i, a_det, exp_dt[i]); end
      total++; if (int'(a_cs) != exp_cs[i]) begin bad++; $display("FAIL ovl_cs[%0d] got=%0d want=%0d", i, a_cs, exp_cs[i]); end
    end
    total++; if (a_cnt !== 8'd2) begin bad++; $display("FAIL ovl_cnt got=%0d want=2", a_cnt); end
  endtask

  task automatic test_no_overlap();
    int bits [6]   = '{1, 0, 1, 0, 1, 0};
    int exp_cs [6] = '{1, 2, 3, 0, 1, 2};
    int exp_dt [6] = '{0, 0, 0, 1, 0, 0};
    overlap_en = 1'b0;
    do_clear();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, bits[i][0]);
      total++; if (a_det !== exp_dt[i][0]) begin bad++; $display("FAIL novl_det[%0d] got=%0d want=%0d", i, a_det, exp_dt[i]); end
      total++; if (int'(a_cs) != exp_cs[i]) begin bad++; $display("FAIL novl_cs[%0d] got=%0d want=%0d", i, a_cs, exp_cs[i]); end
    end
    total++; if (a_cnt !== 8'd1) begin bad++; $display("FAIL novl_cnt got=%0d want=1", a_cnt); end
  endtask

  task automatic test_fallback();
    int bits [5]   = '{1, 1, 0, 1, 1};
    int exp_cs [5] = '{1, 1, 2, 3, 1};
    int exp_dt [5] = '{0, 0, 0, 0, 1};
    overlap_en = 1'b1;
    do_clear();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, bits[i][0]);
      total++; if (b_det !== exp_dt[i][0]) begin bad++; $display("FAIL fb_det[%0d] got=%0d want=%0d", i, b_det, exp_dt[i]); end
      total++; if (int'(b_cs) != exp_cs[i]) begin bad++; $display("FAIL fb_cs[%0d] got=%0d want=%0d", i, b_cs, exp_cs[i]); end
    end
    total++; if (b_cnt !== 8'd1) begin bad++; $display("FAIL fb_cnt got=%0d want=1", b_cnt); end
  endtask

  task automatic test_saturate();
    int exp_cnt [5] = '{1, 2, 3, 3, 3};
    overlap_en = 1'b1;
    do_clear();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int m = 0; m < 5; m++) begin
      step(1'b1, 1'b0);
      total++; if (c_det !== 1'b1) begin bad++; $display("FAIL sat_det[%0d] got=%0d want=1", m, c_det); end
      total++; if (int'(c_cnt) != exp_cnt[m]) begin bad++; $display("FAIL sat_cnt[%0d] got=%0d want=%0d", m, c_cnt, exp_cnt[m]); end
      step(1'b1, 1'b1);
    end
    clear = 1'b1;
    step(1'b1, 1'b0);
    clear = 1'b0;
    total++; if (c_det !== 1'b0) begin bad++; $display("FAIL clr_det got=%0d want=0", c_det); end
    total++; if (c_cnt !== 2'd0) begin bad++; $display("FAIL clr_cnt got=%0d want=0", c_cnt); end
    total++; if (c_cs !== 3'd0) begin bad++; $display("FAIL clr_cs got=%0d want=0", c_cs); end
  endtask

  task automatic test_hold_and_reset();
    overlap_en = 1'b1;
    do_clear();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      total++; if (a_cs !== 3'd2) begin bad++; $display("FAIL hold_cs[%0d] got=%0d want=2", i, a_cs); end
      total++; if (a_det !== 1'b0) begin bad++; $display("FAIL hold_det[%0d] got=%0d want=0", i, a_det); end
    end
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    total++; if (a_det !== 1'b1) begin bad++; $display("FAIL hold_match got=%0d want=1", a_det); end
    total++; if (a_cnt !== 8'd1) begin bad++; $display("FAIL hold_cnt got=%0d want=1", a_cnt); end
    step(1'b0, 1'b0);
    total++; if (a_det !== 1'b0) begin bad++; $display("FAIL pulse_len got=%0d want=0", a_det); end
    step(1'b1, 1'b1);
    total++; if (a_cs !== 3'd3) begin bad++; $display("FAIL pre_rst_cs got=%0d want=3", a_cs); end
    #2 rst = 1'b1;
    #1;
    total++; if (a_cs !== 3'd0) begin bad++; $display("FAIL async_rst_cs got=%0d want=0", a_cs); end
    total++; if (a_cnt !== 8'd0) begin bad++; $display("FAIL async_rst_cnt got=%0d want=0", a_cnt); end
    total++; if (a_det !== 1'b0) begin bad++; $display("FAIL async_rst_det got=%0d want=0", a_det); end
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

`ifdef SEQ_DET_PROG_PATTERN_EN
  task automatic test_prog_pattern();
    int bits1 [4] = '{0, 1, 1, 0};
    int exp1 [4]  = '{0, 0, 0, 1};
    int bits2 [4] = '{1, 0, 1, 0};
    overlap_en = 1'b0;
    do_clear();
    for (int i = 0; i < 4; i++) step(1'b1, bits2[i][0]);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    pat_load = 1'b1;
    pat_in   = 4'b0110;
    step(1'b1, 1'b0);
    pat_load = 1'b0;
    total++; if (a_cs !== 3'd0) begin bad++; $display("FAIL load_cs got=%0d want=0", a_cs); end
    total++; if (a_det !== 1'b0) begin bad++; $display("FAIL load_det got=%0d want=0", a_det); end
    total++; if (a_cnt !== 8'd1) begin bad++; $display("FAIL load_cnt got=%0d want=1", a_cnt); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bits1[i][0]);
      total++; if (a_det !== exp1[i][0]) begin bad++; $display("FAIL prog_det[%0d] got=%0d want=%0d", i, a_det, exp1[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bits2[i][0]);
      total++; if (a_det !== 1'b0) begin bad++; $display("FAIL old_pat_det[%0d] got=%0d want=0", i, a_det); end
    end
    total++; if (a_cnt !== 8'd2) begin bad++; $display("FAIL prog_cnt got=%0d want=2", a_cnt); end
  endtask
`endif

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    din        = 1'b0;
    overlap_en = 1'b0;
    clear      = 1'b0;
`ifdef SEQ_DET_PROG_PATTERN_EN
    pat_load   = 1'b0;
    pat_in     = 4'b0000;
`endif
    test_reset();
    test_overlap();
    test_no_overlap();
    test_fallback();
    test_saturate();
    test_hold_and_reset();
`ifdef SEQ_DET_PROG_PATTERN_EN
    test_prog_pattern();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
